// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write requesters, the FIFO write port and the arbiter.
// The master modport is the arbiter side; slave is the requester/FIFO environment side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic                      grant_valid;
    logic [IdW-1:0]            grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of up to MAX_BURST
// writes into a shared FIFO write port; arbitration costs one idle cycle per tenure.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input logic              clock,
    input logic              resetn,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q;
    logic [IdW-1:0] owner_q;
    logic [IdW-1:0] last_owner_q;
    logic [7:0]     burst_q;

    logic [IdW-1:0] pick;
    logic           any_valid;
    logic           owner_valid;
    logic           beat;

    // Circular search starting just after the previous owner, so it ranks last.
    always_comb begin
        pick      = last_owner_q;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned cand;
            cand = (32'(last_owner_q) + k) % NUM_REQ;
            if (!any_valid && bus.req_valid[cand[IdW-1:0]]) begin
                pick      = cand[IdW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign owner_valid = bus.req_valid[owner_q];
    assign beat        = (state_q == StBusy) && owner_valid && !bus.fifo_full;

    always_comb begin
        bus.req_ready = '0;
        if (state_q == StBusy && !bus.fifo_full) begin
            bus.req_ready[owner_q] = 1'b1;
        end
    end

    assign bus.fifo_wr_en   = beat;
    assign bus.fifo_data_in = beat ? bus.req_data[32'(owner_q) * DATA_W +: DATA_W] : '0;
    assign bus.grant_valid  = (state_q == StBusy);
    assign bus.grant_id     = owner_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IdW'(NUM_REQ - 1);
            burst_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        owner_q <= pick;
                        burst_q <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!owner_valid) begin
                        last_owner_q <= owner_q;
                        state_q      <= StIdle;
                    end else if (beat) begin
                        burst_q <= burst_q + 8'd1;
                        if (burst_q == 8'(MAX_BURST - 1)) begin
                            last_owner_q <= owner_q;
                            state_q      <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of write requesters sharing one FIFO write port (2..8).
REQ-002 Parameter: DATA_W, 32, data word width.
REQ-003 Parameter: MAX_BURST, 8, maximum beats per grant tenure (1..255).
REQ-004 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-005 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-006 Port: req_valid  input  NUM_REQ  bit i = requester i presents a word.
REQ-007 Port: req_data  input  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W].
REQ-008 Port: req_ready  output  NUM_REQ  bit i = requester i word accepted this cycle when req_valid[i] also high.
REQ-009 Port: fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-010 Port: fifo_wr_en  output  1  write strobe to the FIFO.
REQ-011 Port: fifo_data_in  output  DATA_W  write data to the FIFO.
REQ-012 Port: grant_valid  output  1  a requester currently owns the write port.
REQ-013 Port: grant_id  output  clog2(NUM_REQ)  index of current owner; holds the last owner when grant_valid low.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-015 IDLE: if any req_valid bit high, SHALL select the first requester with req_valid high searching circularly from (last_owner+1) mod NUM_REQ, register it as owner, clear burst counter, enter BUSY next cycle; else remain IDLE.
REQ-016 IDLE: req_ready SHALL be all zero and fifo_wr_en low; arbitration costs exactly one cycle.
REQ-017 BUSY: req_ready[owner] SHALL equal !fifo_full; all other req_ready bits zero (combinational from registered owner and fifo_full).
REQ-018 BUSY: fifo_wr_en SHALL equal req_valid[owner] & !fifo_full; fifo_data_in SHALL equal the owner's req_data slice, combinationally, same cycle.
REQ-019 Each beat (fifo_wr_en high) SHALL increment the 8-bit burst counter; no increment when fifo_full stalls.
REQ-020 BUSY SHALL return to IDLE next cycle when req_valid[owner] is low, or when a beat occurs with burst counter at MAX_BURST-1.
REQ-021 fifo_full high in BUSY with req_valid[owner] high SHALL hold ownership indefinitely; no release, no counter change.
REQ-022 last_owner SHALL update to owner on BUSY->IDLE transition; a released owner has lowest priority at next arbitration.
REQ-023 Requests from non-owners SHALL be ignored in BUSY; no preemption.
REQ-024 grant_valid SHALL be high exactly when state is BUSY; grant_id SHALL be the registered owner.
REQ-025 fifo_data_in SHALL be zero whenever fifo_wr_en is low.
REQ-026 At most one requester SHALL be granted in any cycle; fifo_wr_en SHALL never be high while fifo_full is high.

Reset
REQ-027 resetn low SHALL immediately (asynchronously) force state IDLE, owner 0, last_owner NUM_REQ-1, burst counter 0.
REQ-028 During and after reset: req_ready 0, fifo_wr_en 0, fifo_data_in 0, grant_valid 0, grant_id 0; first arbitration favours requester 0.
REQ-029 Reset asserted mid-burst SHALL abort the tenure with no further writes; after release the block SHALL arbitrate from IDLE as in REQ-028.

Verification
REQ-030 Reset, then req_valid=4'b1111 constant, fifo_full=0 -> grant order 0,1,2,3,0; each tenure exactly 8 beats; one idle cycle between tenures.
REQ-031 Requester 2 alone sends 3 words then drops valid -> grant_id=2, 3 consecutive fifo_wr_en pulses with its data, IDLE the cycle after valid drops.
REQ-032 Owner 1 mid-burst at beat 4, fifo_full high 5 cycles -> req_ready=0, fifo_wr_en=0, grant kept; beats 5..8 resume after full drops; total 8 writes.
REQ-033 req_valid=4'b1001, last_owner=3 -> requester 0 granted; after release with both still valid, requester 3 granted.
REQ-034 resetn pulled low asynchronously mid-cycle during BUSY -> all outputs zero before next clock edge; after release, first grant to requester 0 if valid.
REQ-035 Random valid/full stimulus 10k cycles -> scoreboard: FIFO word stream equals per-requester streams in grant order, no loss, no duplication, no write while full.
